lab6_serial_tx: RTL

//   Serial transmitter that drives the 1-bit d line sampled by the lab's D-flip-flop receivers.

---
 rtl/lab6_serial_tx_if.sv | 32 +++
 rtl/lab6_serial_tx.sv | 130 +++++++++++++
 2 files changed

// File: rtl/lab6_serial_tx_if.sv
// Handshake and line-status bundle for lab6_serial_tx: parallel word in, serial line and
// frame status out.
interface lab6_serial_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_out;
  logic              tx_busy;
  logic              tx_done;

  // master: stimulus side that offers words and watches the line
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_out,
    input  tx_busy,
    input  tx_done
  );

  // slave: the transmitter itself
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_out,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/lab6_serial_tx.sv
// Framed serial transmitter: start bit (0), DATA_W data bits LSB first, stop bit (1),
// each bit held CLKS_PER_BIT clocks on a registered, idle-high line.
module lab6_serial_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input logic             clk,
  input logic             rst,
  lab6_serial_tx_if.slave tx
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              out_q, out_d;
  logic              busy_q;
  logic              done_q, done_d;
  logic              bit_end;

  assign bit_end = (cnt_q == CntLast);

  // The line value is computed from the next state so tx_out is a plain flop output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    out_d   = out_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        out_d = 1'b1;
        if (tx.tx_valid) begin
          shift_d = tx.tx_data;
          cnt_d   = '0;
          idx_d   = '0;
          out_d   = 1'b0;
          state_d = StStart;
        end
      end

      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          out_d   = shift_q[0];
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            out_d   = 1'b1;
            state_d = StStop;
          end else begin
            idx_d = idx_q + IdxW'(1);
            out_d = shift_d[0];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StStop: begin
        if (bit_end) begin
          cnt_d   = '0;
          out_d   = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        out_d   = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      out_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= done_d;
    end
  end

  assign tx.tx_ready = (state_q == StIdle);
  assign tx.tx_out   = out_q;
  assign tx.tx_busy  = busy_q;
  assign tx.tx_done  = done_q;

  done_not_busy_a: assert property (@(posedge clk) disable iff (rst) !(done_q && busy_q));
  idle_line_high_a: assert property (@(posedge clk) disable iff (rst)
                                     (state_q == StIdle) |-> out_q);

endmodule
